// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 filter path: widths, pad helper and the
// framing FSM state encoding also referenced by the filter's row counters.
package filter_pkg;

  localparam int PIX_W = 24;
  localparam int CNT_W = 13;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TOP_PAD   = 3'd1,
    ROW_LEAD  = 3'd2,
    ROW_PIX   = 3'd3,
    ROW_TRAIL = 3'd4,
    BOT_PAD   = 3'd5
  } pad_state_t;

  function automatic int pad_f(input int kernel_size);
    return (kernel_size - 1) / 2;
  endfunction

endpackage

// File: rtl/filter_pad_if.sv
// Pixel-source handshake plus padded output stream of the framing stage.
interface filter_pad_if;

  logic                        iStart;
  logic                        iValid;
  logic                        iReady;
  logic [filter_pkg::PIX_W-1:0] iData;
  logic                        oValid;
  logic [filter_pkg::PIX_W-1:0] oData;
  logic                        oDone;
  logic                        oBusy;

  modport slave (
    input  iStart, iValid, iData,
    output iReady, oValid, oData, oDone, oBusy
  );

  modport master (
    output iStart, iValid, iData,
    input  iReady, oValid, oData, oDone, oBusy
  );

endinterface

// File: rtl/filter_pad.sv
// Wraps a raw row-major pixel stream in a zero border of (kernel_size-1)/2
// beats on every side so the downstream 3x3 filter sees a padded frame.
module filter_pad
  import filter_pkg::*;
#(
  parameter int img_width          = 320,
  parameter int img_height         = 240,
  parameter int kernel_size        = 3,
  parameter int row_pipeline_depth = img_width + 2 * ((kernel_size - 1) / 2)
) (
  input logic         clk,
  input logic         reset,
  filter_pad_if.slave bus
);

  localparam int PAD = pad_f(kernel_size);

  localparam logic [CNT_W-1:0] COL_LAST    = CNT_W'(row_pipeline_depth - 1);
  localparam logic [CNT_W-1:0] LEAD_LAST   = CNT_W'(PAD - 1);
  localparam logic [CNT_W-1:0] PIX_LAST    = CNT_W'(PAD + img_width - 1);
  localparam logic [CNT_W-1:0] ROW_LAST    = CNT_W'(img_height - 1);
  localparam logic [CNT_W-1:0] PADROW_LAST = CNT_W'(PAD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  pad_state_t       state_reg, state_next;
  logic [CNT_W-1:0] col_cnt_reg, col_cnt_next;
  logic [CNT_W-1:0] row_cnt_reg, row_cnt_next;
  logic             valid_reg, valid_next;
  logic [PIX_W-1:0] data_reg, data_next;
  logic             done_reg, done_next;
  logic             busy_reg, busy_next;
  logic             row_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      col_cnt_reg <= '0;
      row_cnt_reg <= '0;
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      col_cnt_reg <= col_cnt_next;
      row_cnt_reg <= row_cnt_next;
      valid_reg   <= valid_next;
      data_reg    <= data_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
    end
  end

  // col_cnt runs across lead, pixel and trail segments of one padded row;
  // during TOP_PAD/BOT_PAD row_cnt counts pad rows instead of image rows.
  always_comb begin
    state_next   = state_reg;
    col_cnt_next = col_cnt_reg;
    row_cnt_next = row_cnt_reg;
    valid_next   = 1'b0;
    data_next    = '0;
    done_next    = 1'b0;
    busy_next    = (state_reg != IDLE);
    row_end      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.iStart) begin
          busy_next    = 1'b1;
          col_cnt_next = '0;
          row_cnt_next = '0;
          // with no border the lead segment is empty, so go straight to pixels
          state_next   = (PAD == 0) ? ROW_PIX : TOP_PAD;
        end
      end

      TOP_PAD, BOT_PAD: begin
        valid_next   = 1'b1;
        col_cnt_next = col_cnt_reg + CNT_ONE;
        if (col_cnt_reg == COL_LAST) begin
          col_cnt_next = '0;
          row_cnt_next = row_cnt_reg + CNT_ONE;
          if (row_cnt_reg == PADROW_LAST) begin
            row_cnt_next = '0;
            if (state_reg == TOP_PAD) begin
              state_next = ROW_LEAD;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
      end

      ROW_LEAD: begin
        valid_next   = 1'b1;
        col_cnt_next = col_cnt_reg + CNT_ONE;
        if (col_cnt_reg == LEAD_LAST) begin
          state_next = ROW_PIX;
        end
      end

      ROW_PIX: begin
        if (bus.iValid) begin
          valid_next   = 1'b1;
          data_next    = bus.iData;
          col_cnt_next = col_cnt_reg + CNT_ONE;
          if (col_cnt_reg == PIX_LAST) begin
            if (PAD == 0) begin
              row_end = 1'b1;
            end else begin
              state_next = ROW_TRAIL;
            end
          end
        end
      end

      ROW_TRAIL: begin
        valid_next   = 1'b1;
        col_cnt_next = col_cnt_reg + CNT_ONE;
        if (col_cnt_reg == COL_LAST) begin
          row_end = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase

    if (row_end) begin
      col_cnt_next = '0;
      row_cnt_next = row_cnt_reg + CNT_ONE;
      if (row_cnt_reg == ROW_LAST) begin
        row_cnt_next = '0;
        if (PAD == 0) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = BOT_PAD;
        end
      end else begin
        state_next = (PAD == 0) ? ROW_PIX : ROW_LEAD;
      end
    end
  end

  assign bus.iReady = (state_reg == ROW_PIX);
  assign bus.oValid = valid_reg;
  assign bus.oData  = data_reg;
  assign bus.oDone  = done_reg;
  assign bus.oBusy  = busy_reg;

endmodule
